grf_dump_reader: RTL and testbench

//  Sequential read-side client of the GRF. On a start pulse it drives one GRF read address per slot-free

---
 rtl/grf_pkg.sv | 18 +
 rtl/dump_out_slot.sv | 69 ++++++
 rtl/grf_dump_reader.sv | 110 +++++++++++
 tb/tb_grf_dump_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared constants and dump-FSM state encoding for the GRF dump reader.
//   GRF_NUM_REGS : number of architectural registers scanned
//   GRF_ADDR_W   : GRF read address width
//   GRF_DATA_W   : GRF data width
//   dump_state_e : IDLE / SCAN / DRAIN encoding of the dump sequencer
package grf_pkg;

  localparam int GRF_NUM_REGS = 32;
  localparam int GRF_ADDR_W   = 5;
  localparam int GRF_DATA_W   = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE  = 2'd0,
    DUMP_SCAN  = 2'd1,
    DUMP_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/dump_out_slot.sv
// One-entry valid/ready output register holding a {addr, data, pc} record.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   load             : write in_* into the slot (caller only loads when slot_free)
//   in_addr/data/pc  : record to load
//   slot_free        : slot is empty or its record is being accepted this cycle
//   out_valid/ready  : downstream handshake
//   out_addr/data/pc : held record, stable while out_valid & !out_ready
module dump_out_slot import grf_pkg::*; #(
  parameter int ADDR_W = GRF_ADDR_W,
  parameter int DATA_W = GRF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] in_pc,
  output logic              slot_free,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_pc
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] pc_q, pc_d;

  assign slot_free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = in_addr;
      data_d  = in_data;
      pc_d    = in_pc;
    end else if (out_ready) begin
      // Record (if any) is consumed and nothing replaces it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_addr  = addr_q;
  assign out_data  = data_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/grf_dump_reader.sv
// Debug/trace client that walks GRF registers 0..NUM_REGS-1 after a start
// pulse and streams {addr, data, pc} records over a valid/ready port.
// Ports:
//   clk, reset       : clock, synchronous active-low reset
//   start, pc_tag    : begin a dump (idle only), PC tag attached to every record
//   rd_addr, rd_data : GRF read port (rd_data combinational from rd_addr)
//   out_*            : record stream with valid/ready handshake
//   busy, done       : dump in progress, one-cycle completion pulse
module grf_dump_reader import grf_pkg::*; #(
  parameter int NUM_REGS  = GRF_NUM_REGS,
  parameter int ADDR_W    = GRF_ADDR_W,
  parameter int DATA_W    = GRF_DATA_W,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] pc_tag,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_pc,
  output logic              busy,
  output logic              done
);

  // One spare bit so the index can step past the last register without wrapping.
  localparam int               IDX_W    = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  dump_state_e       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              done_q, done_d;
  logic              slot_free;
  logic              load;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pc_d    = pc_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          pc_d    = pc_tag;
          idx_d   = '0;
          state_d = DUMP_SCAN;
        end
      end
      DUMP_SCAN: begin
        // Backpressure: with the slot full and not being drained, everything holds.
        if (slot_free) begin
          load  = !(SKIP_ZERO && (rd_data == '0));
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = DUMP_DRAIN;
        end
      end
      DUMP_DRAIN: begin
        // slot_free covers both "already empty" and "last record accepted now".
        if (slot_free) begin
          state_d = DUMP_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
    end
  end

  assign rd_addr = idx_q[ADDR_W-1:0];
  assign busy    = (state_q != DUMP_IDLE);
  assign done    = done_q;

  dump_out_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .in_addr   (idx_q[ADDR_W-1:0]),
    .in_data   (rd_data),
    .in_pc     (pc_q),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_pc    (out_pc)
  );

endmodule

// File: tb/tb_grf_dump_reader.sv
module tb_grf_dump_reader;
  import grf_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, out_ready;
  logic [DW-1:0] pc_tag;

  logic [AW-1:0] rd_addr_a, rd_addr_b, out_addr_a, out_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b, out_data_a, out_data_b, out_pc_a, out_pc_b;
  logic          out_valid_a, out_valid_b, busy_a, busy_b, done_a, done_b;

  // GRF model: single writer, writes land on posedge (reads see the old value on that edge).
  logic [DW-1:0] grf [32];
  logic [DW-1:0] pre [32];
  logic          load_all, grf_we;
  logic [AW-1:0] grf_wa;
  logic [DW-1:0] grf_wd;

  always @(posedge clk) begin
    if (load_all) begin
      for (int k = 0; k < 32; k++) grf[k] <= pre[k];
    end else if (grf_we) begin
      grf[grf_wa] <= grf_wd;
    end
  end

  assign rd_data_a = grf[rd_addr_a];
  assign rd_data_b = grf[rd_addr_b];

  grf_dump_reader #(.NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pc_tag(pc_tag),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_addr(out_addr_a), .out_data(out_data_a), .out_pc(out_pc_a),
    .busy(busy_a), .done(done_a)
  );

  grf_dump_reader #(.NUM_REGS(32), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pc_tag(pc_tag),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_addr(out_addr_b), .out_data(out_data_b), .out_pc(out_pc_b),
    .busy(busy_b), .done(done_b)
  );

  // Observed instance: 0 = plain, 1 = SKIP_ZERO.
  logic          sel;
  logic          m_valid, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_pc;
  assign m_valid = sel ? out_valid_b : out_valid_a;
  assign m_busy  = sel ? busy_b      : busy_a;
  assign m_done  = sel ? done_b      : done_a;
  assign m_addr  = sel ? out_addr_b  : out_addr_a;
  assign m_data  = sel ? out_data_b  : out_data_a;
  assign m_pc    = sel ? out_pc_b    : out_pc_a;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] rec_addr [64];
  logic [DW-1:0] rec_data [64];
  logic [DW-1:0] rec_pc   [64];
  int n_rec, done_cnt, done_cyc, first_hs, last_hs;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int mode);
    for (int k = 0; k < 32; k++) begin
      case (mode)
        0:       pre[k] = k * 32'h11;
        1:       pre[k] = (k == 5) ? 32'hDEAD : ((k == 31) ? 32'h1 : 32'h0);
        default: pre[k] = k;
      endcase
    end
    load_all = 1'b1;
    tick();
    load_all = 1'b0;
  endtask

  task automatic start_dump(input logic [DW-1:0] p);
    pc_tag = p;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    $display("[TB] start pc_tag=%08h busy=%0b", p, m_busy);
  endtask

  // Runs the observed dump to its done pulse, logging every handshake.
  task automatic collect(input bit toggle, input int restart_at, input bit wr_test);
    logic [68:0] held;
    bit stalled, wrote7, wrote3;
    n_rec = 0; done_cnt = 0; done_cyc = -1; first_hs = -1; last_hs = -1;
    wrote7 = 1'b0; wrote3 = 1'b0;
    for (int c = 0; c < 300; c++) begin
      out_ready = toggle ? (c % 2 == 0) : 1'b1;
      start     = (c == restart_at);
      if (c == restart_at) pc_tag = 32'h0000_4000;
      grf_we = 1'b0;
      if (wr_test && !wrote7 && busy_a && rd_addr_a == 5'd7) begin
        grf_we = 1'b1; grf_wa = 5'd7; grf_wd = 32'hBEEF; wrote7 = 1'b1;
      end else if (wr_test && wrote7 && !wrote3) begin
        grf_we = 1'b1; grf_wa = 5'd3; grf_wd = 32'h1234; wrote3 = 1'b1;
      end
      stalled = m_valid && !out_ready;
      held    = {m_addr, m_data, m_pc};
      if (m_valid && out_ready) begin
        rec_addr[n_rec] = m_addr;
        rec_data[n_rec] = m_data;
        rec_pc[n_rec]   = m_pc;
        $display("[TB] record %0d addr=%0d data=%08h pc=%08h", n_rec, m_addr, m_data, m_pc);
        n_rec++;
        if (first_hs < 0) first_hs = c;
        last_hs = c;
      end
      tick();
      grf_we = 1'b0;
      start  = 1'b0;
      if (stalled) check("stall_hold", {27'd0, m_valid, m_addr, m_data, m_pc}, {27'd0, 1'b1, held});
      if (m_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cnt > 0) break;
    end
  endtask

  initial begin
    int hs;
    reset = 1'b0; start = 1'b0; out_ready = 1'b1; pc_tag = '0; sel = 1'b0;
    load_all = 1'b0; grf_we = 1'b0; grf_wa = '0; grf_wd = '0;
    tick(); tick();
    check("reset_valid", {95'd0, out_valid_a}, 96'd0);
    check("reset_busy",  {95'd0, busy_a},      96'd0);
    check("reset_done",  {95'd0, done_a},      96'd0);
    check("reset_outs",  {27'd0, rd_addr_a, out_addr_a, out_data_a, out_pc_a}, 96'd0);
    reset = 1'b1;
    tick();

    // 1: full dump, no backpressure.
    preload(0);
    sel = 1'b0;
    start_dump(32'h0000_1000);
    check("t1_busy", {95'd0, busy_a}, 96'd1);
    collect(1'b0, -1, 1'b0);
    check("t1_count", 96'(n_rec), 96'd32);
    for (int k = 0; k < 32; k++)
      check($sformatf("t1_rec%0d", k), {27'd0, rec_addr[k], rec_data[k], rec_pc[k]},
            {27'd0, 5'(k), 32'(k * 32'h11), 32'h0000_1000});
    check("t1_consecutive", 96'(last_hs - first_hs), 96'd31);
    check("t1_done_timing", 96'(done_cyc), 96'(last_hs));
    tick();
    check("t1_done_once", {95'd0, done_a}, 96'd0);
    check("t1_busy_low",  {95'd0, busy_a}, 96'd0);

    // 2: toggling ready, same data.
    start_dump(32'h0000_2000);
    collect(1'b1, -1, 1'b0);
    check("t2_count", 96'(n_rec), 96'd32);
    for (int k = 0; k < 32; k++)
      check($sformatf("t2_rec%0d", k), {27'd0, rec_addr[k], rec_data[k], rec_pc[k]},
            {27'd0, 5'(k), 32'(k * 32'h11), 32'h0000_2000});
    check("t2_done_timing", 96'(done_cyc), 96'(last_hs));
    tick(); tick();

    // 3: SKIP_ZERO instance, sparse register file.
    preload(1);
    sel = 1'b1;
    start_dump(32'h0000_2500);
    collect(1'b0, -1, 1'b0);
    check("t3_count", 96'(n_rec), 96'd2);
    check("t3_rec0", {27'd0, rec_addr[0], rec_data[0], rec_pc[0]}, {27'd0, 5'd5,  32'hDEAD, 32'h0000_2500});
    check("t3_rec1", {27'd0, rec_addr[1], rec_data[1], rec_pc[1]}, {27'd0, 5'd31, 32'h1,    32'h0000_2500});
    check("t3_done", 96'(done_cnt), 96'd1);
    check("t3_done_timing", 96'(done_cyc), 96'(last_hs));
    tick(); tick();

    // 4: second start mid-dump is ignored.
    preload(0);
    sel = 1'b0;
    start_dump(32'h0000_3000);
    collect(1'b0, 5, 1'b0);
    check("t4_count", 96'(n_rec), 96'd32);
    for (int k = 0; k < 32; k++)
      check($sformatf("t4_pc%0d", k), {64'd0, rec_pc[k]}, {64'd0, 32'h0000_3000});
    tick();
    check("t4_no_restart", {95'd0, busy_a}, 96'd0);

    // 5: reset mid-dump.
    start_dump(32'h0000_5000);
    out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (m_valid && out_ready) hs++;
      if (hs == 10) break;
      tick();
    end
    check("t5_ten_records", 96'(hs), 96'd10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("t5_valid", {95'd0, out_valid_a}, 96'd0);
    check("t5_busy",  {94'd0, busy_a, busy_b}, 96'd0);
    check("t5_outs",  {27'd0, rd_addr_a, out_addr_a, out_data_a, out_pc_a}, 96'd0);
    check("t5_done",  {95'd0, done_a}, 96'd0);
    tick();
    check("t5_no_done", {94'd0, done_a, busy_a}, 96'd0);
    $display("[TB] reset mid-dump after %0d records", hs);

    // 6: GRF write on the capturing edge yields the old value.
    preload(2);
    start_dump(32'h0000_6000);
    collect(1'b0, -1, 1'b1);
    check("t6_count", 96'(n_rec), 96'd32);
    check("t6_rec7",  {64'd0, rec_data[7]}, 96'h7);
    check("t6_rec3",  {64'd0, rec_data[3]}, 96'h3);
    check("t6_rec8",  {64'd0, rec_data[8]}, 96'h8);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
